// File: rtl/ann_pkg.sv
// Shared binary32 field definitions and pack/unpack helpers for the ann datapath blocks.
package ann_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;
  localparam logic [31:0] GAMMA_DEFAULT = 32'h3F4C_CCCD;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] ex;
    logic [MAN_W-1:0] man;
  } fp32_t;

  function automatic fp32_t fp32_unpack(input logic [31:0] x);
    return fp32_t'(x);
  endfunction

  // Significand with hidden bit; subnormals flush to zero here.
  function automatic logic [MAN_W:0] fp32_sig(input fp32_t f);
    return (f.ex == '0) ? '0 : {1'b1, f.man};
  endfunction

  function automatic logic [31:0] fp32_pack(input logic sign, input logic [EXP_W-1:0] ex,
                                            input logic [MAN_W-1:0] man);
    return {sign, ex, man};
  endfunction

  function automatic logic [31:0] fp32_inf(input logic sign);
    return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

endpackage

// File: rtl/ann_fp32_mul.sv
// Registered binary32 multiplier: 24x24 significand product, normalize, round, pack in one cycle.
// ANN_TD_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the product is truncated.
module ann_fp32_mul
  import ann_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        vld_p1,
  output logic [31:0] prod_p1
);

`ifdef ANN_TD_ROUND_NEAREST_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  function automatic logic [24:0] round_sig(input logic [23:0] sig, input logic [2:0] grs);
    logic inc;
    inc = RNE_EN & grs[2] & (grs[1] | grs[0] | sig[0]);
    return {1'b0, sig} + 25'(inc);
  endfunction

  fp32_t             fa;
  fp32_t             fb;
  logic [47:0]       prod;
  logic [23:0]       sig;
  logic [2:0]        grs;
  logic [24:0]       rnd;
  logic signed [9:0] exp_r;
  logic [22:0]       man;
  logic [31:0]       prod_nxt;

  always_comb begin
    fa    = fp32_unpack(a);
    fb    = fp32_unpack(b);
    prod  = 48'(fp32_sig(fa)) * 48'(fp32_sig(fb));
    exp_r = signed'({2'b00, fa.ex}) + signed'({2'b00, fb.ex}) - signed'(10'(BIAS));
    if (prod[47]) begin
      sig   = prod[47:24];
      grs   = {prod[23], prod[22], |prod[21:0]};
      exp_r = exp_r + 10'sd1;
    end else begin
      sig   = prod[46:23];
      grs   = {prod[22], prod[21], |prod[20:0]};
    end
    rnd = round_sig(sig, grs);
    if (rnd[24]) begin
      man   = rnd[23:1];
      exp_r = exp_r + 10'sd1;
    end else begin
      man   = rnd[22:0];
    end
    if (prod == '0 || exp_r <= 10'sd0) prod_nxt = FP32_ZERO;
    else if (exp_r >= 10'sd255)         prod_nxt = fp32_inf(fa.sign ^ fb.sign);
    else                                prod_nxt = fp32_pack(fa.sign ^ fb.sign, exp_r[7:0], man);
  end

  // ---- stage 1 register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld;
  end

  always_ff @(posedge clk) begin
    if (vld) prod_p1 <= prod_nxt;
  end

endmodule

// File: rtl/ann_td_target.sv
// DQN temporal-difference target: loss = done ? reward : reward + GAMMA*q_max, binary32, 3-cycle pipeline.
// Define ANN_TD_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module ann_td_target
  import ann_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] GAMMA      = GAMMA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_reward_valid,
  input  logic [DATA_WIDTH-1:0] i_reward,
  input  logic                  i_done,
  input  logic                  i_q_max_valid,
  input  logic [DATA_WIDTH-1:0] i_q_max,
  output logic [DATA_WIDTH-1:0] o_loss_value,
  output logic                  o_loss_value_valid
);

`ifdef ANN_TD_ROUND_NEAREST_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  function automatic logic [24:0] round_sig(input logic [23:0] sig, input logic [2:0] grs);
    logic inc;
    inc = RNE_EN & grs[2] & (grs[1] | grs[0] | sig[0]);
    return {1'b0, sig} + 25'(inc);
  endfunction

  // Right shift that ORs every bit pushed out into the sticky LSB.
  function automatic logic [26:0] shift_sticky(input logic [26:0] x, input logic [7:0] d);
    logic [26:0] y;
    logic        lost;
    if (d >= 8'd27) begin
      y    = '0;
      lost = |x;
    end else begin
      y    = x >> d;
      lost = |(x & ~({27{1'b1}} << d));
    end
    return {y[26:1], y[0] | lost};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] x);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (x[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  logic [DATA_WIDTH-1:0] reward_reg;
  logic                  done_reg;
  logic [DATA_WIDTH-1:0] reward_in;
  logic                  done_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reward_reg <= '0;
      done_reg   <= 1'b0;
    end else if (i_reward_valid) begin
      reward_reg <= i_reward;
      done_reg   <= i_done;
    end
  end

  // A reward arriving with the q_max strobe is used directly.
  assign reward_in = i_reward_valid ? i_reward : reward_reg;
  assign done_in   = i_reward_valid ? i_done   : done_reg;

  // ---- stage 1: GAMMA*q_max, capture reward/done ----
  logic                  vld_p1;
  logic [31:0]           prod_p1;
  logic [DATA_WIDTH-1:0] reward_p1;
  logic                  done_p1;

  ann_fp32_mul u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (i_q_max_valid),
    .a       (GAMMA),
    .b       (i_q_max),
    .vld_p1  (vld_p1),
    .prod_p1 (prod_p1)
  );

  always_ff @(posedge clk) begin
    if (i_q_max_valid) begin
      reward_p1 <= reward_in;
      done_p1   <= done_in;
    end
  end

  // ---- stage 2: align smaller operand, add/subtract magnitudes ----
  fp32_t       op_p;
  fp32_t       op_r;
  fp32_t       op_a;
  fp32_t       op_b;
  logic [7:0]  shamt;
  logic [26:0] sig_a;
  logic [26:0] sig_b;
  logic [27:0] sum;

  always_comb begin
    op_p = fp32_unpack(prod_p1);
    op_r = fp32_unpack(reward_p1);
    if ({op_r.ex, op_r.man} > {op_p.ex, op_p.man}) begin
      op_a = op_r;
      op_b = op_p;
    end else begin
      op_a = op_p;
      op_b = op_r;
    end
    shamt = op_a.ex - op_b.ex;
    sig_a = {fp32_sig(op_a), 3'b000};
    sig_b = shift_sticky({fp32_sig(op_b), 3'b000}, shamt);
    if (op_a.sign == op_b.sign) sum = {1'b0, sig_a} + {1'b0, sig_b};
    else                        sum = {1'b0, sig_a} - {1'b0, sig_b};
  end

  logic                  vld_p2;
  logic [27:0]           sum_p2;
  logic signed [9:0]     exp_p2;
  logic                  sign_p2;
  logic                  done_p2;
  logic [DATA_WIDTH-1:0] reward_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      sum_p2    <= sum;
      exp_p2    <= signed'({2'b00, op_a.ex});
      sign_p2   <= op_a.sign;
      done_p2   <= done_p1;
      reward_p2 <= reward_p1;
    end
  end

  // ---- stage 3: normalize, round, pack ----
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_n;
  logic [24:0]       rnd;
  logic [22:0]       man_n;
  logic [31:0]       loss_nxt;

  always_comb begin
    lz = lzc27(sum_p2[26:0]);
    if (sum_p2[27]) begin
      norm  = {sum_p2[27:2], sum_p2[1] | sum_p2[0]};
      exp_n = exp_p2 + 10'sd1;
    end else begin
      norm  = sum_p2[26:0] << lz;
      exp_n = exp_p2 - signed'({5'b00000, lz});
    end
    rnd = round_sig(norm[26:3], norm[2:0]);
    if (rnd[24]) begin
      man_n = rnd[23:1];
      exp_n = exp_n + 10'sd1;
    end else begin
      man_n = rnd[22:0];
    end
    if (sum_p2 == '0 || exp_n <= 10'sd0) loss_nxt = FP32_ZERO;
    else if (exp_n >= 10'sd255)          loss_nxt = fp32_inf(sign_p2);
    else                                 loss_nxt = fp32_pack(sign_p2, exp_n[7:0], man_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_loss_value_valid <= 1'b0;
      o_loss_value       <= '0;
    end else begin
      o_loss_value_valid <= vld_p2;
      if (vld_p2) o_loss_value <= done_p2 ? reward_p2 : loss_nxt;
    end
  end

endmodule

// File: tb/tb_ann_td_target.sv
// Bench for ann_td_target: directed cases and randomized traffic against an exact-integer reference model.
module tb_ann_td_target;
  import ann_pkg::*;

`ifdef ANN_TD_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  localparam logic [31:0] GAMMA_TB = 32'h3F4CCCCD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_reward_valid;
  logic [31:0] i_reward;
  logic        i_done;
  logic        i_q_max_valid;
  logic [31:0] i_q_max;
  logic [31:0] o_loss_value;
  logic        o_loss_value_valid;

  ann_td_target #(.DATA_WIDTH(32), .GAMMA(GAMMA_TB)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_reward_valid     (i_reward_valid),
    .i_reward           (i_reward),
    .i_done             (i_done),
    .i_q_max_valid      (i_q_max_valid),
    .i_q_max            (i_q_max),
    .o_loss_value       (o_loss_value),
    .o_loss_value_valid (o_loss_value_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  // value = mag * 2^e ; subnormals decode as zero
  function automatic void fp_dec(input logic [31:0] x, output bit s, output logic [127:0] mag,
                                 output int e);
    s = x[31];
    if (x[30:23] == 8'd0) begin
      mag = '0;
      e   = 0;
    end else begin
      mag = 128'({1'b1, x[22:0]});
      e   = int'(x[30:23]) - 150;
    end
  endfunction

  function automatic logic [31:0] m_round(input bit s, input logic [127:0] mag, input int e);
    int p, sh, be;
    logic [127:0] m, rem, half;
    if (mag == '0) return 32'h0;
    p = 127;
    while (mag[p] == 1'b0) p--;
    sh = p - 23;
    if (sh > 0) begin
      m    = mag >> sh;
      rem  = mag - (m << sh);
      half = 128'd1 << (sh - 1);
      if (RNE && (rem > half || (rem == half && m[0]))) begin
        m = m + 128'd1;
        if (m[24]) begin
          m  = m >> 1;
          sh = sh + 1;
        end
      end
    end else begin
      m = mag << (-sh);
    end
    be = e + sh + 23 + 127;
    if (be <= 0)   return 32'h0;
    if (be >= 255) return {s, 8'hFF, 23'h0};
    return {s, 8'(be), m[22:0]};
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] q);
    bit sg, sq;
    logic [127:0] mg, mq;
    int eg, eq;
    fp_dec(GAMMA_TB, sg, mg, eg);
    fp_dec(q, sq, mq, eq);
    if (mg == '0 || mq == '0) return 32'h0;
    return m_round(sg ^ sq, mg * mq, eg + eq);
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    bit sx, sy;
    logic [127:0] mx, my, ax, ay;
    int ex, ey, emin;
    fp_dec(x, sx, mx, ex);
    fp_dec(y, sy, my, ey);
    if (mx == '0) ex = ey;
    if (my == '0) ey = ex;
    emin = (ex < ey) ? ex : ey;
    ax = mx << (ex - emin);
    ay = my << (ey - emin);
    if (sx == sy) return m_round(sx, ax + ay, emin);
    if (ax >= ay) return m_round(sx, ax - ay, emin);
    return m_round(sy, ay - ax, emin);
  endfunction

  typedef struct { int due; logic [31:0] val; } exp_t;
  exp_t        sb[$];
  logic [31:0] m_reward = 32'h0;
  bit          m_done = 1'b0;
  logic [31:0] last_out = 32'h0;
  bit          running = 1'b0;
  bit          exp_v;

  // One input cycle; expectation from the model unless use_exp supplies a fixed value.
  task automatic drive(input bit rv, input logic [31:0] r, input bit d, input bit qv,
                       input logic [31:0] q, input bit use_exp, input logic [31:0] want);
    logic [31:0] v;
    @(posedge clk);
    #1;
    i_reward_valid = rv;
    i_reward       = r;
    i_done         = d;
    i_q_max_valid  = qv;
    i_q_max        = q;
    if (rv) begin
      m_reward = r;
      m_done   = d;
    end
    if (qv) begin
      v = use_exp ? want : (m_done ? m_reward : m_add(m_mul(q), m_reward));
      sb.push_back('{cyc + 3, v});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, $urandom, 1'($urandom), 1'b0, $urandom, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rnd_fp(input int lo, input int hi);
    if ($urandom_range(15, 0) == 0) return 32'h0;
    return {1'($urandom), 8'($urandom_range(hi, lo)), 23'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (running && rst_n) begin
      exp_v = 1'b0;
      if (sb.size() != 0) exp_v = (sb[0].due == cyc);
      check("valid", 32'(o_loss_value_valid), 32'(exp_v));
      if (exp_v) begin
        check("loss", o_loss_value, sb[0].val);
        last_out = sb[0].val;
        void'(sb.pop_front());
      end else begin
        check("hold", o_loss_value, last_out);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_reward_valid = 1'b0; i_reward = 32'h0; i_done = 1'b0;
    i_q_max_valid = 1'b0;  i_q_max = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(o_loss_value_valid), 32'h0);
    check("rst_loss", o_loss_value, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    running = 1'b1;

    drive(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 1'b1, 32'h40266666);
    idle(4);
    drive(1'b1, 32'h3F800000, 1'b1, 1'b1, 32'h40000000, 1'b1, 32'h3F800000);
    idle(4);
    drive(1'b1, 32'h00000000, 1'b0, 1'b1, 32'h3F800000, 1'b1, 32'h3F4CCCCD);
    idle(4);
    drive(1'b1, 32'hBF800000, 1'b0, 1'b1, 32'h3FA00000, 1'b1, 32'h00000000);
    idle(4);
    drive(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'hBFA00000, 1'b1, 32'h00000000);
    idle(4);
    // back-to-back q_max sharing one reward
    drive(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 1'b1, 32'h40266666);
    drive(1'b0, 32'h12345678, 1'b1, 1'b1, 32'h00000000, 1'b1, 32'h3F800000);
    drive(1'b0, 32'h12345678, 1'b1, 1'b1, 32'h40000000, 1'b1, 32'h40266666);
    idle(4);
    // overflow, underflow flush, subnormal inputs, done bypass of a subnormal
    drive(1'b1, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 1'b1, 32'h7F800000);
    drive(1'b1, 32'hFF7FFFFF, 1'b0, 1'b1, 32'hFF7FFFFF, 1'b1, 32'hFF800000);
    drive(1'b1, 32'h00000000, 1'b0, 1'b1, 32'h00800000, 1'b1, 32'h00000000);
    drive(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h00000001, 1'b1, 32'h3F800000);
    drive(1'b1, 32'h00000010, 1'b0, 1'b1, 32'h00000000, 1'b1, 32'h00000000);
    drive(1'b1, 32'h00000010, 1'b1, 1'b1, 32'h40000000, 1'b1, 32'h00000010);
    idle(4);

    // reset one cycle after a q_max strobe: nothing emerges, stored reward cleared
    drive(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_reward_valid = 1'b0; i_q_max_valid = 1'b0;
    sb.delete();
    m_reward = 32'h0; m_done = 1'b0; last_out = 32'h0;
    @(negedge clk);
    check("midrst_valid", 32'(o_loss_value_valid), 32'h0);
    check("midrst_loss", o_loss_value, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40000000, 1'b1, 32'h3FCCCCCD);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] q, r, p;
      bit rv, qv, d;
      rv = ($urandom_range(2, 0) == 0);
      qv = 1'($urandom);
      d  = ($urandom_range(3, 0) == 0);
      q  = rnd_fp(115, 140);
      r  = rnd_fp(112, 142);
      p  = m_mul(q);
      case ($urandom_range(5, 0))
        0: r = {~p[31], p[30:0]};
        1: r = {~p[31], p[30:4], 4'($urandom)};
        default: ;
      endcase
      drive(rv, r, d, qv, q, 1'b0, 32'h0);
    end
    idle(6);
    check("drain", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
